// File: rtl/hamming_pkg.sv
// Shared SECDED definitions: codeword bit positions, TX state encoding and the encoder.
// Also imported by the receive-side detector model.
package hamming_pkg;

  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int W0 = 2;
  localparam int P2 = 3;
  localparam int W1 = 4;
  localparam int W2 = 5;
  localparam int W3 = 6;
  localparam int G0 = 7;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  function automatic logic [7:0] hamming_encode(input logic [3:0] w);
    logic [7:0] cw;
    cw     = '0;
    cw[W0] = w[0];
    cw[W1] = w[1];
    cw[W2] = w[2];
    cw[W3] = w[3];
    cw[P0] = w[0] ^ w[1] ^ w[3];
    cw[P1] = w[0] ^ w[2] ^ w[3];
    cw[P2] = w[1] ^ w[2] ^ w[3];
    // Overall parity makes a clean word read back with a zero syndrome.
    cw[G0] = ^cw[6:0];
    return cw;
  endfunction

endpackage

// File: rtl/hamming_serializer.sv
// UART-style frame generator: start bit, 8 data bits LSB first, stop bit,
// each held BAUD_DIV cycles.
//
// state    | meaning
// TX_IDLE  | line high, waiting for a start strobe
// TX_START | start bit (low)
// TX_DATA  | data bit bit_idx of the latched word
// TX_STOP  | stop bit (high); tx_done pulses on the way back to idle
module hamming_serializer
  import hamming_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] load_data,
  input  logic       start,
  output tx_state_t  state,
  output logic       tx_bit,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned BW = $clog2(BAUD_DIV + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  tx_state_t   state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  data_q;
  logic        tx_bit_q;
  logic        tx_busy_q;
  logic        tx_done_q;

  logic        baud_last;
  logic [2:0]  next_idx;

  assign baud_last = (baud_q == BAUD_LAST);
  assign next_idx  = bit_idx_q + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= TX_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      tx_bit_q  <= 1'b1;
      tx_busy_q <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (state_q)
        TX_IDLE: begin
          if (start) begin
            state_q   <= TX_START;
            data_q    <= load_data;
            baud_q    <= '0;
            bit_idx_q <= '0;
            tx_bit_q  <= 1'b0;
            tx_busy_q <= 1'b1;
          end
        end
        TX_START: begin
          if (baud_last) begin
            state_q   <= TX_DATA;
            baud_q    <= '0;
            bit_idx_q <= '0;
            tx_bit_q  <= data_q[0];
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        TX_DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q  <= TX_STOP;
              tx_bit_q <= 1'b1;
            end else begin
              bit_idx_q <= next_idx;
              tx_bit_q  <= data_q[next_idx];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        TX_STOP: begin
          if (baud_last) begin
            state_q   <= TX_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            tx_busy_q <= 1'b0;
            tx_done_q <= 1'b1;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q   <= TX_IDLE;
          tx_bit_q  <= 1'b1;
          tx_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign state   = state_q;
  assign tx_bit  = tx_bit_q;
  assign tx_busy = tx_busy_q;
  assign tx_done = tx_done_q;

endmodule

// File: rtl/hamming_encoder_tx.sv
// SECDED transmit path: accepts a nibble, encodes it with optional error injection,
// holds the codeword for the detector and serializes it on tx_bit.
module hamming_encoder_tx
  import hamming_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic       err_en,
  input  logic [7:0] err_mask,
  output logic [7:0] codeword,
  output logic       cw_valid,
  output logic       tx_bit,
  output logic       tx_busy,
  output logic       tx_done
);

  tx_state_t  tx_state;
  logic       accept;
  logic [7:0] codeword_d, codeword_q;
  logic       cw_valid_d, cw_valid_q;

  assign din_ready = (tx_state == TX_IDLE) & ~rst;
  assign accept    = din_valid & din_ready;

  // Error controls only matter in the accept cycle; the result is frozen for the frame.
  always_comb begin
    codeword_d = codeword_q;
    cw_valid_d = 1'b0;
    if (accept) begin
      codeword_d = hamming_encode(din) ^ (err_en ? err_mask : 8'h00);
      cw_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      codeword_q <= 8'h00;
      cw_valid_q <= 1'b0;
    end else begin
      codeword_q <= codeword_d;
      cw_valid_q <= cw_valid_d;
    end
  end

  assign codeword = codeword_q;
  assign cw_valid = cw_valid_q;

  hamming_serializer #(
    .BAUD_DIV(BAUD_DIV)
  ) u_serializer (
    .clk      (clk),
    .rst      (rst),
    .load_data(codeword_d),
    .start    (accept),
    .state    (tx_state),
    .tx_bit   (tx_bit),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

endmodule

// File: tb/tb_hamming_encoder_tx.sv
// Bench for hamming_encoder_tx: vector table at BAUD_DIV=4, streaming at BAUD_DIV=1,
// mid-frame reset abort.
module tb_hamming_encoder_tx;

  logic clk = 1'b0;
  logic rst;

  logic [3:0] din_4, din_1;
  logic       din_valid_4, din_valid_1;
  logic       din_ready_4, din_ready_1;
  logic       err_en_4, err_en_1;
  logic [7:0] err_mask_4, err_mask_1;
  logic [7:0] codeword_4, codeword_1;
  logic       cw_valid_4, cw_valid_1;
  logic       tx_bit_4, tx_bit_1;
  logic       tx_busy_4, tx_busy_1;
  logic       tx_done_4, tx_done_1;

  always #5 clk = ~clk;

  hamming_encoder_tx #(.BAUD_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .din(din_4), .din_valid(din_valid_4), .din_ready(din_ready_4),
    .err_en(err_en_4), .err_mask(err_mask_4), .codeword(codeword_4), .cw_valid(cw_valid_4),
    .tx_bit(tx_bit_4), .tx_busy(tx_busy_4), .tx_done(tx_done_4)
  );

  hamming_encoder_tx #(.BAUD_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .din(din_1), .din_valid(din_valid_1), .din_ready(din_ready_1),
    .err_en(err_en_1), .err_mask(err_mask_1), .codeword(codeword_1), .cw_valid(cw_valid_1),
    .tx_bit(tx_bit_1), .tx_busy(tx_busy_1), .tx_done(tx_done_1)
  );

  typedef struct {
    logic [3:0] din;
    logic       err_en;
    logic [7:0] mask;
    logic [7:0] exp_cw;
    logic [3:0] exp_syn;
  } vec_t;

  vec_t       vecs [8];
  logic [3:0] nib [6];
  logic [7:0] cw_q4 [$];
  logic [7:0] cw_q1 [$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_encode(input logic [3:0] d);
    logic p0, p1, p2, g;
    p0 = d[0] ^ d[1] ^ d[3];
    p1 = d[0] ^ d[2] ^ d[3];
    p2 = d[1] ^ d[2] ^ d[3];
    g  = d[3] ^ d[2] ^ d[1] ^ p2 ^ d[0] ^ p1 ^ p0;
    return {g, d[3], d[2], d[1], p2, d[0], p1, p0};
  endfunction

  // Detector view: {overall parity, position bits}.
  function automatic logic [3:0] syndrome(input logic [7:0] c);
    logic s0, s1, s2, g;
    s0 = c[0] ^ c[2] ^ c[4] ^ c[6];
    s1 = c[1] ^ c[2] ^ c[5] ^ c[6];
    s2 = c[3] ^ c[4] ^ c[5] ^ c[6];
    g  = ^c;
    return {g, s2, s1, s0};
  endfunction

  function automatic logic [39:0] exp_frame(input logic [7:0] c, input int b);
    logic [39:0] f;
    int j;
    f = '0;
    for (int k = 0; k < 10 * b; k++) begin
      j = k / b;
      if (j == 0)      f[k] = 1'b0;
      else if (j == 9) f[k] = 1'b1;
      else             f[k] = c[j-1];
    end
    return f;
  endfunction

  task automatic send4(input logic [3:0] d, input logic en, input logic [7:0] m,
                       input logic [7:0] ecw, input logic [3:0] esyn, input bit intrude);
    logic [7:0]  exp_cw;
    logic [39:0] act, efr;
    int          lat;
    bit          bad_hs, bad_pulse;
    @(negedge clk);
    check("ready_before", din_ready_4, 1);
    din_4 = d; err_en_4 = en; err_mask_4 = m; din_valid_4 = 1'b1;
    cw_q4.push_back(ecw);
    @(negedge clk);
    din_valid_4 = 1'b0; din_4 = ~d; err_en_4 = 1'b1; err_mask_4 = 8'hFF;
    lat = 1;
    while (!cw_valid_4 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check("cw_latency", lat, 1);
    if (!cw_valid_4) begin
      cw_q4.delete();
      err_en_4 = 1'b0;
      return;
    end
    exp_cw = cw_q4.pop_front();
    check("codeword", codeword_4, exp_cw);
    check("syndrome", syndrome(codeword_4), esyn);
    efr = exp_frame(exp_cw, 4);
    act = '0; bad_hs = 0; bad_pulse = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      act[k] = tx_bit_4;
      if (k > 0 && cw_valid_4) bad_pulse = 1;
      if (din_ready_4 || !tx_busy_4 || tx_done_4) bad_hs = 1;
      if (intrude && k == 4)  begin din_4 = 4'hF; din_valid_4 = 1'b1; end
      if (intrude && k == 30) din_valid_4 = 1'b0;
    end
    check("frame_bits", act, efr);
    check("busy_no_ready", bad_hs, 0);
    check("cw_valid_pulse", bad_pulse, 0);
    @(negedge clk);
    check("tx_done", tx_done_4, 1);
    check("ready_at_done", din_ready_4, 1);
    check("cw_hold", codeword_4, exp_cw);
    @(negedge clk);
    check("tx_done_pulse", tx_done_4, 0);
    err_en_4 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int sent, got, last_cw, fpos, busy_run, idle_run;
    bit acc_pending, ready_bad, saw_busy, saw_done;
    logic [7:0]  cur_exp;
    logic [39:0] fr_exp, fr_act;

    vecs[0] = '{4'b1011, 1'b0, 8'h00, 8'h55, 4'h0};
    vecs[1] = '{4'h0,    1'b0, 8'h00, 8'h00, 4'h0};
    vecs[2] = '{4'hF,    1'b0, 8'h00, 8'hFF, 4'h0};
    vecs[3] = '{4'b0001, 1'b0, 8'h00, 8'h87, 4'h0};
    vecs[4] = '{4'b1011, 1'b1, 8'h04, 8'h51, 4'b1011};
    vecs[5] = '{4'b1011, 1'b1, 8'h05, 8'h50, 4'b0010};
    vecs[6] = '{4'b0110, 1'b0, 8'h00, 8'h33, 4'h0};
    vecs[7] = '{4'b0110, 1'b0, 8'hFF, 8'h33, 4'h0};
    nib = '{4'h5, 4'hA, 4'h3, 4'hC, 4'h6, 4'h9};

    rst = 1'b1;
    din_4 = '0; din_valid_4 = 1'b0; err_en_4 = 1'b0; err_mask_4 = '0;
    din_1 = '0; din_valid_1 = 1'b0; err_en_1 = 1'b0; err_mask_1 = '0;
    #2;
    check("rst_codeword", codeword_4, 8'h00);
    check("rst_cw_valid", cw_valid_4, 0);
    check("rst_tx_bit", tx_bit_4, 1);
    check("rst_tx_busy", tx_busy_4, 0);
    check("rst_tx_done", tx_done_4, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_rst", din_ready_4, 1);
    check("tx_bit_idle", tx_bit_4, 1);

    for (int i = 0; i < 8; i++)
      send4(vecs[i].din, vecs[i].err_en, vecs[i].mask, vecs[i].exp_cw, vecs[i].exp_syn, i == 0);

    // Streaming at one cycle per bit with din_valid held high.
    sent = 0; got = 0; last_cw = -1; fpos = 11; busy_run = 0; idle_run = 0;
    acc_pending = 0; ready_bad = 0; saw_busy = 0;
    fr_exp = '0; fr_act = '0;
    @(negedge clk);
    din_1 = nib[0]; din_valid_1 = 1'b1;
    if (din_ready_1) begin
      cw_q1.push_back(model_encode(din_1)); sent++; acc_pending = 1;
    end
    for (int cyc = 0; cyc < 300 && !(got == 6 && fpos == 11); cyc++) begin
      @(negedge clk);
      if (acc_pending) begin
        acc_pending = 0;
        if (sent < 6) din_1 = nib[sent];
        else          din_valid_1 = 1'b0;
      end
      if (cw_valid_1) begin
        check("s_queue_nonempty", cw_q1.size() > 0, 1);
        cur_exp = (cw_q1.size() > 0) ? cw_q1.pop_front() : 8'hxx;
        check("s_codeword", codeword_1, cur_exp);
        if (last_cw >= 0) check("s_spacing", cyc - last_cw, 11);
        last_cw = cyc;
        got++;
        fr_exp = exp_frame(cur_exp, 1);
        fr_act = '0;
        fpos = 0;
      end
      if (fpos < 10) begin
        fr_act[fpos] = tx_bit_1;
        fpos++;
        if (fpos == 10) check("s_frame_bits", fr_act, fr_exp);
      end else if (fpos == 10) begin
        check("s_tx_done", tx_done_1, 1);
        fpos = 11;
      end
      if (tx_busy_1) begin
        if (din_ready_1) ready_bad = 1;
        if (busy_run == 0 && saw_busy) check("s_idle_gap", idle_run, 1);
        busy_run++;
        idle_run = 0;
      end else begin
        if (busy_run > 0) begin
          check("s_frame_len", busy_run, 10);
          saw_busy = 1;
        end
        busy_run = 0;
        idle_run++;
      end
      if (din_valid_1 && din_ready_1) begin
        cw_q1.push_back(model_encode(din_1));
        sent++;
        acc_pending = 1;
      end
    end
    din_valid_1 = 1'b0;
    check("s_sent", sent, 6);
    check("s_got", got, 6);
    check("s_queue_empty", cw_q1.size(), 0);
    check("s_ready_low_busy", ready_bad, 0);

    // Reset during data bit 3 of 0x55 (that bit is 0, so the line visibly returns high).
    @(negedge clk);
    din_4 = 4'b1011; err_en_4 = 1'b0; err_mask_4 = 8'h00; din_valid_4 = 1'b1;
    cw_q4.push_back(8'h55);
    @(negedge clk);
    din_valid_4 = 1'b0;
    check("a_cw_valid", cw_valid_4, 1);
    cur_exp = cw_q4.pop_front();
    check("a_codeword", codeword_4, cur_exp);
    repeat (17) @(negedge clk);
    check("a_pre_rst_bit", tx_bit_4, 0);
    check("a_pre_rst_busy", tx_busy_4, 1);
    rst = 1'b1;
    #1;
    check("a_rst_tx_bit", tx_bit_4, 1);
    check("a_rst_codeword", codeword_4, 8'h00);
    check("a_rst_busy", tx_busy_4, 0);
    saw_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (tx_done_4) saw_done = 1;
    end
    rst = 1'b0;
    repeat (45) begin
      @(negedge clk);
      if (tx_done_4 || tx_busy_4) saw_done = 1;
    end
    check("a_no_done", saw_done, 0);
    send4(4'b0001, 1'b0, 8'h00, 8'h87, 4'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
